rtc_time_set_ctrl: RTL and testbench

- Time-setting controller for the real-time clock.
- Consumes three debounced button levels (mode, inc, dec) and steps through hour/minute/second edit fields.
- Holds the edited values and issues a one-cycle load pulse that writes them into the RTC counter core.
- Sits between the per-button debouncers and the RTC timekeeping core; also drives display blink/field select.

---
 rtl/rtc_pkg.sv | 46 ++++
 rtl/rtc_key_repeat.sv | 68 ++++++
 rtl/rtc_time_set_ctrl.sv | 156 +++++++++++++++
 tb/tb_rtc_time_set_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-setting controller.
// Optional feature macro used by this slice: RTC_SET_AUTOREPEAT_EN.
package rtc_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HH = 3'd1,
        SET_MM = 3'd2,
        SET_SS = 3'd3,
        LOAD   = 3'd4
    } state_t;

    localparam int HH_W = 5;
    localparam int MM_W = 6;
    localparam int SS_W = 6;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HH   = 2'd1;
    localparam logic [1:0] FIELD_MM   = 2'd2;
    localparam logic [1:0] FIELD_SS   = 2'd3;

    localparam logic [HH_W-1:0] HH_MAX = 5'd23;
    localparam logic [MM_W-1:0] MM_MAX = 6'd59;
    localparam logic [SS_W-1:0] SS_MAX = 6'd59;

    // Hours step up with an explicit wrap at the top of the range
    function automatic logic [HH_W-1:0] hh_up(input logic [HH_W-1:0] val);
        return (val >= HH_MAX) ? '0 : val + 5'd1;
    endfunction

    // Hours step down with an explicit wrap at zero
    function automatic logic [HH_W-1:0] hh_down(input logic [HH_W-1:0] val);
        return (val == '0) ? HH_MAX : val - 5'd1;
    endfunction

    // Minutes/seconds step up, wrapping 59 -> 0
    function automatic logic [MM_W-1:0] ms_up(input logic [MM_W-1:0] val);
        return (val >= MM_MAX) ? '0 : val + 6'd1;
    endfunction

    // Minutes/seconds step down, wrapping 0 -> 59
    function automatic logic [MM_W-1:0] ms_down(input logic [MM_W-1:0] val);
        return (val == '0) ? MM_MAX : val - 6'd1;
    endfunction

endpackage

// File: rtl/rtc_key_repeat.sv
// Edge detector for one step button, with an optional hold/auto-repeat
// counter (enabled by RTC_SET_AUTOREPEAT_EN). Emits a one-cycle step pulse.
module rtc_key_repeat
`ifdef RTC_SET_AUTOREPEAT_EN
#(
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter int unsigned CNT_W         = 32
)
`endif
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    input  logic enable_i,
`ifdef RTC_SET_AUTOREPEAT_EN
    input  logic other_i,
    input  logic clear_i,
`endif
    output logic step_o
);

    logic key_q;
    logic rise;

    assign rise = key_i & ~key_q;

    // Remember last button level so a rise can be seen
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key_i;
        end
    end

`ifdef RTC_SET_AUTOREPEAT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             rep_q;
    logic             run;
    logic             fire;

    assign run  = key_i & ~other_i & enable_i & ~clear_i;
    assign fire = run & (rep_q ? (cnt_q == CNT_W'(REPEAT_CYCLES))
                               : (cnt_q == CNT_W'(HOLD_CYCLES)));

    // Count held cycles; first repeat after the hold delay, then at the repeat rate
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else if (!run) begin
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else if (fire) begin
            cnt_q <= CNT_W'(1);
            rep_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign step_o = enable_i & (rise | fire);
`else
    assign step_o = enable_i & rise;
`endif

endmodule

// File: rtl/rtc_time_set_ctrl.sv
// Time-setting controller: walks hour/minute/second edit fields on mode
// presses, steps the active field on inc/dec, then pulses load_o once.
// Optional auto-repeat on held inc/dec: RTC_SET_AUTOREPEAT_EN.
module rtc_time_set_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter int unsigned CNT_W         = 32
)
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mode_i,
    input  logic            inc_i,
    input  logic            dec_i,
    input  logic [HH_W-1:0] cur_hh_i,
    input  logic [MM_W-1:0] cur_mm_i,
    input  logic [SS_W-1:0] cur_ss_i,
    output logic            set_active_o,
    output logic [1:0]      field_o,
    output logic [HH_W-1:0] hh_o,
    output logic [MM_W-1:0] mm_o,
    output logic [SS_W-1:0] ss_o,
    output logic            load_o
);

    state_t          state_q, state_d;
    logic [HH_W-1:0] hh_q, hh_d;
    logic [MM_W-1:0] mm_q, mm_d;
    logic [SS_W-1:0] ss_q, ss_d;
    logic            mode_q;
    logic            mode_rise;
    logic            editing;
    logic            inc_step, dec_step;
    logic            step_up, step_dn;

    assign mode_rise = mode_i & ~mode_q;
    assign editing   = (state_q == SET_HH) | (state_q == SET_MM) | (state_q == SET_SS);

`ifdef RTC_SET_AUTOREPEAT_EN
    rtc_key_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_inc (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .key_i    (inc_i),
        .enable_i (editing),
        .other_i  (dec_i),
        .clear_i  (mode_rise),
        .step_o   (inc_step)
    );

    rtc_key_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_dec (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .key_i    (dec_i),
        .enable_i (editing),
        .other_i  (inc_i),
        .clear_i  (mode_rise),
        .step_o   (dec_step)
    );
`else
    rtc_key_repeat u_inc (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .key_i    (inc_i),
        .enable_i (editing),
        .step_o   (inc_step)
    );

    rtc_key_repeat u_dec (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .key_i    (dec_i),
        .enable_i (editing),
        .step_o   (dec_step)
    );
`endif

    // Opposing steps in the same cycle cancel; a mode press drops any step
    assign step_up = inc_step & ~dec_step & ~mode_rise;
    assign step_dn = dec_step & ~inc_step & ~mode_rise;

    // State, edit values and mode edge register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            hh_q    <= '0;
            mm_q    <= '0;
            ss_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            mode_q  <= mode_i;
        end
    end

    // Next state, field edits and decoded outputs
    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        field_o = FIELD_NONE;
        load_o  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mode_rise) begin
                    hh_d    = cur_hh_i;
                    mm_d    = cur_mm_i;
                    ss_d    = cur_ss_i;
                    state_d = SET_HH;
                end
            end
            SET_HH: begin
                field_o = FIELD_HH;
                if (mode_rise)    state_d = SET_MM;
                else if (step_up) hh_d = hh_up(hh_q);
                else if (step_dn) hh_d = hh_down(hh_q);
            end
            SET_MM: begin
                field_o = FIELD_MM;
                if (mode_rise)    state_d = SET_SS;
                else if (step_up) mm_d = ms_up(mm_q);
                else if (step_dn) mm_d = ms_down(mm_q);
            end
            SET_SS: begin
                field_o = FIELD_SS;
                if (mode_rise)    state_d = LOAD;
                else if (step_up) ss_d = ms_up(ss_q);
                else if (step_dn) ss_d = ms_down(ss_q);
            end
            LOAD: begin
                load_o  = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign set_active_o = (field_o != FIELD_NONE);
    assign hh_o         = hh_q;
    assign mm_o         = mm_q;
    assign ss_o         = ss_q;

endmodule

// File: tb/tb_rtc_time_set_ctrl.sv
// Self-checking bench for rtc_time_set_ctrl: directed steps from the test
// plan followed by random button activity against a behavioural model.
module tb_rtc_time_set_ctrl;

    localparam int HOLD = 10;
    localparam int REP  = 4;

    logic       clk;
    logic       rst_n;
    logic       mode, inc, dec;
    logic [4:0] cur_hh;
    logic [5:0] cur_mm, cur_ss;
    logic       set_active;
    logic [1:0] field;
    logic [4:0] hh;
    logic [5:0] mm, ss;
    logic       load;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase 0=run, 1..3=editing hh/mm/ss, 4=load
    int m_phase, m_hh, m_mm, m_ss, k_inc, k_dec;
    bit pm, pi, pd;

    rtc_time_set_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .CNT_W         (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mode_i       (mode),
        .inc_i        (inc),
        .dec_i        (dec),
        .cur_hh_i     (cur_hh),
        .cur_mm_i     (cur_mm),
        .cur_ss_i     (cur_ss),
        .set_active_o (set_active),
        .field_o      (field),
        .hh_o         (hh),
        .mm_o         (mm),
        .ss_o         (ss),
        .load_o       (load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        m_phase = 0; m_hh = 0; m_mm = 0; m_ss = 0;
        k_inc = 0; k_dec = 0;
        pm = 0; pi = 0; pd = 0;
    endtask

    // One clock of the model: decide press effects from the levels seen this cycle
    task automatic modelClock();
        bit mr, ir, dr, edit, fi, fd, up, dn;
        mr = mode && !pm;
        ir = inc && !pi;
        dr = dec && !pd;
        edit = (m_phase >= 1) && (m_phase <= 3);
        fi = 0;
        fd = 0;
`ifdef RTC_SET_AUTOREPEAT_EN
        if (edit && inc && !dec && !mr) begin
            fi = (k_inc >= HOLD) && (((k_inc - HOLD) % REP) == 0);
            k_inc++;
        end else begin
            k_inc = 0;
        end
        if (edit && dec && !inc && !mr) begin
            fd = (k_dec >= HOLD) && (((k_dec - HOLD) % REP) == 0);
            k_dec++;
        end else begin
            k_dec = 0;
        end
`endif
        up = edit && (ir || fi);
        dn = edit && (dr || fd);
        if (m_phase == 0) begin
            if (mr) begin
                m_hh = cur_hh; m_mm = cur_mm; m_ss = cur_ss;
                m_phase = 1;
            end
        end else if (m_phase == 4) begin
            m_phase = 0;
        end else if (mr) begin
            m_phase++;
        end else if (up != dn) begin
            case (m_phase)
                1: m_hh = up ? (m_hh + 1) % 24 : (m_hh + 23) % 24;
                2: m_mm = up ? (m_mm + 1) % 60 : (m_mm + 59) % 60;
                default: m_ss = up ? (m_ss + 1) % 60 : (m_ss + 59) % 60;
            endcase
        end
        pm = mode; pi = inc; pd = dec;
    endtask

    task automatic checkOutput(input string tag);
        logic [20:0] obs, exp;
        int f;
        f = (m_phase <= 3) ? m_phase : 0;
        obs = {set_active, field, hh, mm, ss, load};
        exp = {(f != 0), 2'(f), 5'(m_hh), 6'(m_mm), 6'(m_ss), (m_phase == 4)};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h (act/fld/hh/mm/ss/load)", tag, obs, exp);
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive levels for one cycle, advance the model, then check at the falling edge
    task automatic applyStimulus(input logic m, input logic i, input logic d, input string tag);
        mode = m; inc = i; dec = d;
        @(posedge clk);
        if (!rst_n) modelReset();
        else        modelClock();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic pulse(input logic m, input logic i, input logic d, input string tag);
        applyStimulus(m, i, d, tag);
        applyStimulus(1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        int exp_ss;
        rst_n = 1'b0; mode = 0; inc = 0; dec = 0;
        cur_hh = 5'd12; cur_mm = 6'd34; cur_ss = 6'd56;
        modelReset();
        #12;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Capture live time on entering edit
        applyStimulus(1'b1, 1'b0, 1'b0, "enter_hh");
        checkValue("capture_hh", hh, 12);
        checkValue("capture_mm", mm, 34);
        checkValue("capture_ss", ss, 56);
        checkValue("field_hh", field, 1);
        checkValue("active_hh", set_active, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, "release");

        // Hours up to 23, then wrap to 0
        for (int n = 0; n < 11; n++) pulse(1'b0, 1'b1, 1'b0, "hh_inc");
        checkValue("hh_23", hh, 23);
        pulse(1'b0, 1'b1, 1'b0, "hh_wrap");
        checkValue("hh_wrap", hh, 0);

        // Minutes down to 0, then wrap to 59
        pulse(1'b1, 1'b0, 1'b0, "to_mm");
        checkValue("field_mm", field, 2);
        for (int n = 0; n < 34; n++) pulse(1'b0, 1'b0, 1'b1, "mm_dec");
        checkValue("mm_0", mm, 0);
        pulse(1'b0, 1'b0, 1'b1, "mm_wrap");
        checkValue("mm_wrap", mm, 59);
        checkValue("ss_kept", ss, 56);

        // Seconds field, then load for one cycle and back to run
        pulse(1'b1, 1'b0, 1'b0, "to_ss");
        checkValue("field_ss", field, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, "to_load");
        checkValue("load_hi", load, 1);
        checkValue("load_field", field, 0);
        checkValue("load_mm", mm, 59);
        applyStimulus(1'b0, 1'b0, 1'b0, "after_load");
        checkValue("load_lo", load, 0);
        checkValue("hold_hh", hh, 0);

        // Simultaneous presses
        pulse(1'b1, 1'b0, 1'b0, "enter_again");
        applyStimulus(1'b0, 1'b1, 1'b1, "inc_dec_same");
        checkValue("both_no_step", hh, 12);
        applyStimulus(1'b0, 1'b0, 1'b0, "release");
        applyStimulus(1'b1, 1'b1, 1'b0, "mode_inc_same");
        checkValue("mode_wins_field", field, 2);
        checkValue("mode_wins_hh", hh, 12);
        checkValue("mode_wins_mm", mm, 34);
        applyStimulus(1'b0, 1'b0, 1'b0, "release");

        // Asynchronous reset while editing minutes
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        checkValue("async_field", field, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, "post_reset");
            checkValue("no_load", load, 0);
        end

        // Hold inc in seconds field from 0
        cur_hh = 5'd5; cur_mm = 6'd6; cur_ss = 6'd0;
        pulse(1'b1, 1'b0, 1'b0, "ar_hh");
        pulse(1'b1, 1'b0, 1'b0, "ar_mm");
        pulse(1'b1, 1'b0, 1'b0, "ar_ss");
        for (int n = 0; n < 30; n++) applyStimulus(1'b0, 1'b1, 1'b0, "ar_hold");
        applyStimulus(1'b0, 1'b0, 1'b0, "ar_release");
`ifdef RTC_SET_AUTOREPEAT_EN
        exp_ss = 6;
`else
        exp_ss = 1;
`endif
        checkValue("hold_ss", ss, exp_ss);

        // Random button activity
        for (int n = 0; n < 600; n++) begin
            logic m, i, d;
            m = mode; i = inc; d = dec;
            if ($urandom_range(7) == 0) m = ~m;
            if ($urandom_range(5) == 0) i = ~i;
            if ($urandom_range(5) == 0) d = ~d;
            cur_hh = 5'($urandom_range(23));
            cur_mm = 6'($urandom_range(59));
            cur_ss = 6'($urandom_range(59));
            applyStimulus(m, i, d, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
